// File: rtl/seq_divider_8bit.sv
// Iterative unsigned restoring divider: one quotient bit per clock by trial
// subtraction, with a start/done handshake around the datapath.
module seq_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SUM_W = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Adds the inverted divisor with carry-in 1; the top bit is the carry-out.
  function automatic logic [SUM_W-1:0] trial_sub(input logic [WIDTH:0]   pr,
                                                 input logic [WIDTH-1:0] dv);
    return {1'b0, pr} + {1'b0, ~{1'b0, dv}} + SUM_W'(1);
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] qreg_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [SUM_W-1:0] trial;
  logic             carry;
  logic [WIDTH-1:0] prem_d;
  logic [WIDTH-1:0] qreg_d;
  logic             unused_trial_msb;

  // A kept remainder is always below the divisor, so only WIDTH bits are stored.
  always_comb begin
    shifted = {prem_q, qreg_q[WIDTH-1]};
    trial   = trial_sub(shifted, dvsr_q);
    carry   = trial[WIDTH+1];
    prem_d  = carry ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    qreg_d  = {qreg_q[WIDTH-2:0], carry};
  end

  assign unused_trial_msb = trial[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prem_q  <= '0;
      qreg_q  <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == RUN) begin
        prem_q <= prem_d;
        qreg_q <= qreg_d;
        cnt_q  <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_q <= FIN;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          quot_q  <= qreg_d;
          rem_q   <= prem_d;
        end
      end else if (start) begin
        // Accepted from IDLE or from FIN, which gives back-to-back operation.
        dvsr_q <= divisor;
        prem_q <= '0;
        qreg_q <= dividend;
        dbz_q  <= 1'b0;
        if (divisor == '0) begin
          state_q <= FIN;
          done_q  <= 1'b1;
          quot_q  <= '1;
          rem_q   <= dividend;
          dbz_q   <= 1'b1;
        end else begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          cnt_q   <= CNT_W'(WIDTH);
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Directed bench for seq_divider_8bit: handshake timing, results, divide by
// zero, busy-start rejection, back-to-back, async reset and an operand sweep.
module tb_seq_divider_8bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider_8bit #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got busy/done/dbz=%b required 000", {busy, done, div_by_zero});
    end
    total++;
    if ({quotient, remainder} !== 16'h0000) begin
      bad++; $display("FAIL reset_data got q=%0d r=%0d required 0 0", quotient, remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL idle_after_reset got busy/done=%b required 00", {busy, done});
    end
  endtask

  // Single division from IDLE with hand-computed results and latency.
  task automatic test_divide(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] eq, input logic [7:0] er,
                             input logic edz, input int elat, input string nm);
    int  cyc;
    int  bcnt;
    bit  seen;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    cyc = 1; bcnt = 0; seen = 0;
    while (!seen && cyc <= 20) begin
      if (busy) bcnt++;
      if (done) seen = 1;
      else begin @(negedge clk); cyc++; end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s_timeout no done within 20 cycles", nm);
    end
    total++;
    if (cyc != elat) begin
      bad++; $display("FAIL %s_latency got done at cycle %0d required %0d", nm, cyc, elat);
    end
    total++;
    if (bcnt != elat - 1) begin
      bad++; $display("FAIL %s_busy got %0d busy cycles required %0d", nm, bcnt, elat - 1);
    end
    total++;
    if (quotient !== eq || remainder !== er) begin
      bad++; $display("FAIL %s_result got q=%0d r=%0d required q=%0d r=%0d", nm, quotient, remainder, eq, er);
    end
    total++;
    if (div_by_zero !== edz) begin
      bad++; $display("FAIL %s_dbz got %b required %b", nm, div_by_zero, edz);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL %s_pulse got done=%b one cycle later required 0", nm, done);
    end
  endtask

  task automatic test_results();
    test_divide(8'd200, 8'd7,   8'd28,  8'd4, 1'b0, 9, "d200_7");
    test_divide(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 9, "d255_1");
    test_divide(8'd5,   8'd9,   8'd0,   8'd5, 1'b0, 9, "d5_9");
    test_divide(8'd0,   8'd3,   8'd0,   8'd0, 1'b0, 9, "d0_3");
    test_divide(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 9, "d255_255");
  endtask

  task automatic test_div_zero();
    test_divide(8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1, "d100_0");
    repeat (3) @(negedge clk);
    total++;
    if (div_by_zero !== 1'b1 || quotient !== 8'd255 || remainder !== 8'd100) begin
      bad++; $display("FAIL dbz_hold got dbz=%b q=%0d r=%0d required 1 255 100", div_by_zero, quotient, remainder);
    end
    test_divide(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 9, "d10_3");
  endtask

  task automatic test_back_to_back();
    int dcnt;
    int k;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (k = 1; k <= 9; k++) begin
      if (k == 3) begin start = 1'b1; dividend = 8'd9; divisor = 8'd2; end
      if (k == 4) start = 1'b0;
      if (done) dcnt++;
      if (k < 9) @(negedge clk);
    end
    total++;
    if (dcnt != 1 || done !== 1'b1) begin
      bad++; $display("FAIL ignore_busy got %0d dones, done@9=%b required 1 and 1", dcnt, done);
    end
    total++;
    if (quotient !== 8'd28 || remainder !== 8'd4) begin
      bad++; $display("FAIL ignore_busy_result got q=%0d r=%0d required 28 4", quotient, remainder);
    end
    // Start presented during the FIN cycle.
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (k = 1; k <= 9; k++) begin
      if (done) dcnt++;
      if (k < 9) @(negedge clk);
    end
    total++;
    if (dcnt != 1 || done !== 1'b1) begin
      bad++; $display("FAIL b2b_timing got %0d dones, done@9=%b required 1 and 1", dcnt, done);
    end
    total++;
    if (quotient !== 8'd4 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL b2b_result got q=%0d r=%0d dbz=%b required 4 1 0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dcnt;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, div_by_zero} !== 3'b000 || {quotient, remainder} !== 16'h0000) begin
      bad++; $display("FAIL async_reset got busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
                      busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    total++;
    if (dcnt != 0) begin
      bad++; $display("FAIL no_done_after_reset got %0d active cycles required 0", dcnt);
    end
    test_divide(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 9, "d50_6");
  endtask

  // Back-to-back sweep with start held high; next operands set in each FIN cycle.
  task automatic test_sweep();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eq;
    logic [7:0] er;
    int  cyc;
    int  elat;
    for (int ia = 0; ia <= 255; ia += 17) begin
      for (int ib = 0; ib <= 255; ib += 3) begin
        a = 8'(ia); b = 8'(ib);
        if (b == 8'd0) begin eq = 8'd255; er = a; elat = 1; end
        else begin eq = a / b; er = a % b; elat = 9; end
        start = 1'b1; dividend = a; divisor = b;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done && cyc < 20);
        total++;
        if (!done || cyc != elat || quotient !== eq || remainder !== er || div_by_zero !== (b == 8'd0)) begin
          bad++;
          $display("FAIL sweep %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d required q=%0d r=%0d dbz=%b lat=%0d",
                   a, b, quotient, remainder, div_by_zero, cyc, eq, er, b == 8'd0, elat);
        end
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_results();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
